vpu_sched: RTL

VPU_SCHED -- requirements
Module: vpu_sched

---
 rtl/vpu_pkg.sv | 27 ++
 rtl/vpu_sched_if.sv | 25 ++
 rtl/vpu_inst_fifo.sv | 59 +++++
 rtl/vpu_sched.sv | 126 ++++++++++++
 4 files changed

// File: rtl/vpu_pkg.sv
// Shared types for the VPU instruction scheduler: instruction field layout,
// opcode constants and the scheduler state encoding.
package vpu_pkg;

  localparam logic [3:0] OP_NOP = 4'd0;

  typedef struct packed {
    logic [7:0] rsvd;
    logic [4:0] cnst;
    logic [4:0] c;
    logic [4:0] b;
    logic [4:0] a;
    logic [3:0] op;
  } inst_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    BUSY   = 2'd2,
    RETIRE = 2'd3
  } sched_state_t;

  function automatic logic is_nop(input logic [3:0] op);
    return op == OP_NOP;
  endfunction

endpackage

// File: rtl/vpu_sched_if.sv
// Host-side instruction push and VPU-side issue handshake of the scheduler.
// master = host/VPU environment, slave = vpu_sched.
interface vpu_sched_if #(
  parameter int INST_W = 32
);
  logic              in_valid;
  logic [INST_W-1:0] in_inst;
  logic              in_ready;
  logic              flush;
  logic [INST_W-1:0] vpu_inst;
  logic              vpu_mem_rdy;
  logic              vpu_mem_read_en;
  logic              vpu_mem_write_en;
  logic              vpu_done;

  modport master (
    output in_valid, in_inst, flush, vpu_done,
    input  in_ready, vpu_inst, vpu_mem_rdy, vpu_mem_read_en, vpu_mem_write_en
  );

  modport slave (
    input  in_valid, in_inst, flush, vpu_done,
    output in_ready, vpu_inst, vpu_mem_rdy, vpu_mem_read_en, vpu_mem_write_en
  );
endinterface

// File: rtl/vpu_inst_fifo.sv
// Instruction FIFO with no bypass; flush can keep the head entry when it has
// already been issued to the VPU.
module vpu_inst_fifo #(
  parameter int DEPTH  = 4,
  parameter int INST_W = 32,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic              keep_head,
  input  logic [INST_W-1:0] din,
  output logic [INST_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [CW-1:0]     count
);

  logic [DEPTH-1:0][INST_W-1:0] mem;
  logic [AW-1:0] rptr, wptr, rptr_nx;
  logic          do_push, do_pop, keep;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rptr];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty;
  assign rptr_nx = do_pop ? rptr + AW'(1) : rptr;
  // An issued head survives a flush unless it is retiring this very cycle.
  assign keep    = keep_head && !do_pop && !empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else if (flush) begin
      rptr  <= rptr_nx;
      wptr  <= keep ? rptr_nx + AW'(1) : rptr_nx;
      count <= keep ? CW'(1) : '0;
    end else begin
      rptr <= rptr_nx;
      if (do_push) wptr <= wptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/vpu_sched.sv
// VPU instruction scheduler: queues host instructions, retires NOPs locally,
// issues the rest to the VPU one at a time. Optional watchdog: VPU_SCHED_WDOG_EN.
module vpu_sched
  import vpu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int INST_W  = 32,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  vpu_sched_if.slave               bus,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [CNT_W-1:0]         retired_cnt,
  output logic                     err_timeout
);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (TIMEOUT < 1)) begin : g_param_chk
    $error("vpu_sched: DEPTH must be a power of 2 >= 2 and TIMEOUT >= 1");
  end

  sched_state_t      state;
  logic [INST_W-1:0] head, inst_q;
  logic              full, empty;
  logic              start, nop_pop, ret_pop, wd_hit, pop;
  logic              rdy_q, rd_q, wr_q;

  // NOP retirement and issue both wait out a flush so a discarded head is
  // never counted or sent to the VPU.
  assign nop_pop = (state == IDLE) && !empty && !bus.flush && is_nop(head[3:0]);
  assign start   = (state == IDLE) && !empty && !bus.flush && !is_nop(head[3:0]);
  assign ret_pop = (state == RETIRE);
  assign pop     = nop_pop || ret_pop || wd_hit;

  assign bus.in_ready         = !full && !bus.flush;
  assign bus.vpu_inst         = inst_q;
  assign bus.vpu_mem_rdy      = rdy_q;
  assign bus.vpu_mem_read_en  = rd_q;
  assign bus.vpu_mem_write_en = wr_q;
  assign busy                 = (state != IDLE);

  vpu_inst_fifo #(.DEPTH(DEPTH), .INST_W(INST_W)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (bus.in_valid),
    .pop       (pop),
    .flush     (bus.flush),
    .keep_head (state != IDLE),
    .din       (bus.in_inst),
    .dout      (head),
    .full      (full),
    .empty     (empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      inst_q <= '0;
      rdy_q  <= 1'b0;
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state  <= ISSUE;
          inst_q <= head;
          rdy_q  <= 1'b1;
          rd_q   <= 1'b1;
          wr_q   <= 1'b1;
        end
        ISSUE: begin
          state <= BUSY;
          rdy_q <= 1'b0;
        end
        BUSY: if (bus.vpu_done) begin
          state <= RETIRE;
          rd_q  <= 1'b0;
          wr_q  <= 1'b0;
        end else if (wd_hit) begin
          state  <= IDLE;
          inst_q <= '0;
          rd_q   <= 1'b0;
          wr_q   <= 1'b0;
        end
        RETIRE: begin
          state  <= IDLE;
          inst_q <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    retired_cnt <= '0;
    else if (nop_pop || ret_pop) retired_cnt <= retired_cnt + CNT_W'(1);
  end

`ifdef VPU_SCHED_WDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            err_q;

  // Fires on the TIMEOUT-th BUSY cycle without vpu_done; done wins a tie.
  assign wd_hit      = (state == BUSY) && !bus.vpu_done && (wd_cnt == WD_W'(TIMEOUT - 1));
  assign err_timeout = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state == ISSUE)                wd_cnt <= '0;
      else if (state == BUSY && !wd_hit) wd_cnt <= wd_cnt + WD_W'(1);
      err_q <= wd_hit || (err_q && !bus.flush);
    end
  end
`else
  assign wd_hit      = 1'b0;
  assign err_timeout = 1'b0;
`endif

endmodule
